// File: rtl/layer_sequencer_if.sv
// Start/valid run-control bundle between the layer sequencer (master) and the
// engines plus host/debug logic (slave).
interface layer_sequencer_if #(
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 32
);
    localparam int CUR_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                  run;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_valid;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [CUR_W-1:0]      cur_layer;
    logic                  busy;
    logic                  done;
    logic                  err_timeout;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        input  run, abort, layer_valid,
        output layer_start, cur_layer, busy, done, err_timeout, cycle_count
    );

    modport slave (
        output run, abort, layer_valid,
        input  layer_start, cur_layer, busy, done, err_timeout, cycle_count
    );
endinterface

// File: rtl/layer_sequencer.sv
// Sequences NUM_LAYERS engines in strict order over a start/valid handshake,
// inserting a one-cycle gap between engines and timing out silent layers.
module layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    layer_sequencer_if.master         bus
);
    localparam int CUR_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam logic [CUR_W-1:0] LAST_LAYER = CUR_W'(NUM_LAYERS - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CUR_W-1:0]      cur_q, cur_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [NUM_LAYERS-1:0] start_q, start_d;
    logic                  cur_valid_s;

    // Next-state, counters and the registered-output images of the next state.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        cur_valid_s = bus.layer_valid[cur_q];

        if ((state_q == ST_RUN || state_q == ST_GAP) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.run && !bus.abort) begin
                    state_d  = ST_RUN;
                    cur_d    = {CUR_W{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    err_d    = 1'b0;
                    to_cnt_d = {TO_W{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            // Priority: abort, then the current layer's valid, then timeout.
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cur_valid_s) begin
                    to_cnt_d = {TO_W{1'b0}};
                    if (cur_q == LAST_LAYER) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        cur_d   = cur_q + CUR_W'(1);
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_GAP: begin
                to_cnt_d = {TO_W{1'b0}};
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_RUN) || (state_d == ST_GAP);
        start_d = {NUM_LAYERS{1'b0}};
        if (state_d == ST_RUN) begin
            start_d[cur_d] = 1'b1;
        end else begin
            start_d = {NUM_LAYERS{1'b0}};
        end
    end

    // State and registered outputs; reset drops every start asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cur_q    <= {CUR_W{1'b0}};
            to_cnt_q <= {TO_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= {NUM_LAYERS{1'b0}};
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            to_cnt_q <= to_cnt_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
        end
    end

    assign bus.layer_start = start_q;
    assign bus.cur_layer   = cur_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Top-level run controller that drives the `start`/`valid` handshake of up to `NUM_LAYERS` compute engines in strict order. It is the initiating end of the start/valid protocol. It holds each engine's `start` high until that engine raises `valid`, then advances to the next engine. It reports overall completion, per-run cycle count and timeouts to the host/debug logic.

## Interface
- `NUM_LAYERS`, default 4: number of engines sequenced (≥1).
- `TIMEOUT`, default 1024: max cycles a layer may hold `start` without `valid` (≥2).
- `CNT_W`, default 32: width of `cycle_count`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: pulse or level; sampled only in IDLE to begin a run.
- `abort` input 1: synchronous abort, any state.
- `layer_valid` input NUM_LAYERS: per-engine completion, level.
- `layer_start` output NUM_LAYERS: per-engine start, one-hot or zero.
- `cur_layer` output $clog2(NUM_LAYERS) (min 1): index of the engine currently started.
- `busy` output 1: high in RUN and GAP.
- `done` output 1: one-cycle pulse when the last layer completes.
- `err_timeout` output 1: sticky; set on timeout, cleared on next accepted `run`.
- `cycle_count` output CNT_W: cycles of the last/current run; saturates at all-ones.

## Operation
- States: IDLE, RUN, GAP, ERROR.
- IDLE: all `layer_start`=0. If `run`=1 and `abort`=0, next state is RUN, with `cur_layer`=0, `cycle_count`=0, `err_timeout`=0, and timeout counter=0.
- RUN: `layer_start[cur_layer]`=1, all other bits 0. `busy`=1. The timeout counter increments each cycle.
  - `layer_valid[cur_layer]`=1, not last layer → GAP; `cur_layer` increments on entry to GAP.
  - `layer_valid[cur_layer]`=1, last layer → IDLE, with `done`=1 for exactly one cycle (the first IDLE cycle).
  - Timeout counter reaches TIMEOUT-1 with no valid → ERROR, `err_timeout`=1.
  - Valid and timeout in the same cycle: valid wins.
- GAP: exactly one cycle with all `layer_start`=0. This guarantees a start falling edge between engines. Timeout counter clears. Next state is RUN.
- ERROR: all `layer_start`=0, `busy`=0. Next state is IDLE. `err_timeout` stays set.
- `layer_valid` bits other than `cur_layer` are ignored in every state. `layer_valid` is ignored in IDLE, GAP and ERROR.
- `run` while `busy` is ignored. A `run` held high in IDLE after `done` starts a new run; it is level-sensitive by design.
- `abort`=1 in any non-IDLE state → IDLE next cycle. All starts are 0 from that cycle, with no `done` and `err_timeout` unchanged. `abort` has priority over valid and timeout.
- `cycle_count` increments every cycle in RUN and GAP and saturates. It holds its value in IDLE/ERROR until the next accepted `run`.

## Timing
- Reset (async assert, sync release): state=IDLE; `layer_start`=0, `cur_layer`=0, `busy`=0, `done`=0, `err_timeout`=0, `cycle_count`=0, timeout counter=0.
- Reset asserted mid-run drops `layer_start` immediately (asynchronously). No `done` is issued.
- All outputs are registered; there are no combinational input-to-output paths.
- `run` high at edge N → `layer_start[0]` high after edge N+1.
- `layer_valid[i]` high at edge M → `layer_start[i]` low after edge M. `layer_start[i+1]` high after edge M+1.
- Last layer: `done` is high for the single cycle after edge M, and `busy` is low in that same cycle.
- Minimum run length: each layer takes ≥1 RUN cycle, plus NUM_LAYERS-1 GAP cycles. With immediate valids, `cycle_count` = 2·NUM_LAYERS-1.
- Timeout: `layer_start` is high for exactly TIMEOUT cycles. `err_timeout` is high from the following cycle.

## Test plan
- **Reset values.** Check all outputs 0 during reset. Pulse `run` at cycle 5 → `layer_start`=0001 at cycle 6.
- **Nominal run.** NUM_LAYERS=4; engine i returns valid 3+i cycles after its start rises, held until start falls. Required: start order 0001→0000→0010→0000→0100→0000→1000. `done` is a single pulse, `cycle_count`=21 (3+4+5+6 RUN cycles plus 3 GAP cycles), `err_timeout`=0.
- **Immediate valid.** All `layer_valid` tied to 1 → `cycle_count`=7. Each start is high for one cycle, with a 1-cycle gap between starts.
- **Timeout.** TIMEOUT=16; engine 2 never answers → `layer_start[2]` high for 16 cycles, then `err_timeout`=1, no `done`, return to IDLE. A new `run` clears `err_timeout`.
- **Abort and spurious valid.** `layer_valid[3]` pulsed while on layer 1 → ignored. `abort` asserted while on layer 2, in the same cycle as `layer_valid[2]` → IDLE, no `done`, layer 3 never started.
- **Async reset mid-run.** Deassert `rst_n` mid-cycle during layer 1 → `layer_start` goes 0 before the next edge. After release, `run` restarts cleanly from layer 0.
